// File: rtl/fib_stack_pkg.sv
// Shared constants and the operation decode for the Fibonacci operand stack.
// The optional sticky error flag is built only when FIB_STACK_ERR_EN is defined.
package fib_stack_pkg;

    localparam int FIB_STACK_WIDTH = 8;
    localparam int FIB_STACK_DEPTH = 16;

    // Encoding matches {push, pop} so the decode is a plain cast.
    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_POP  = 2'b01,
        STK_PUSH = 2'b10,
        STK_REPL = 2'b11
    } stk_op_t;

    function automatic stk_op_t stk_decode(input logic push, input logic pop);
        return stk_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/fib_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module fib_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fib_stack.sv
// LIFO operand stack driven by single-cycle push/pop strobes from the controller.
// Define FIB_STACK_ERR_EN to add the sticky overflow/underflow flag on port err.
module fib_stack
    import fib_stack_pkg::*;
#(
    parameter int WIDTH = FIB_STACK_WIDTH,
    parameter int DEPTH = FIB_STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic                     is_empty,
    output logic                     is_full,
`ifdef FIB_STACK_ERR_EN
    output logic                     err,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] SP_FULL = (AW + 1)'(DEPTH);

    // Strobes carry no handshake: each is level-sampled on every rising edge,
    // may repeat back-to-back, and is dropped (flagged in err) when it cannot apply.
    stk_op_t          op;
    logic [AW:0]      sp, sp_nxt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    waddr;
    logic             we;
    logic             ovf, unf;
    logic [WIDTH-1:0] rdata;

    assign op       = stk_decode(push, pop);
    assign is_empty = (sp == '0);
    assign is_full  = (sp == SP_FULL);
    assign count    = sp;
    assign top_idx  = sp[AW-1:0] - AW'(1);
    assign top      = is_empty ? '0 : rdata;

    always_comb begin
        sp_nxt = sp;
        we     = 1'b0;
        waddr  = sp[AW-1:0];
        ovf    = 1'b0;
        unf    = 1'b0;
        case (op)
            STK_PUSH: begin
                if (is_full) begin
                    ovf = 1'b1;
                end else begin
                    we     = 1'b1;
                    sp_nxt = sp + SP_ONE;
                end
            end
            STK_POP: begin
                if (is_empty) begin
                    unf = 1'b1;
                end else begin
                    sp_nxt = sp - SP_ONE;
                end
            end
            STK_REPL: begin
                we = 1'b1;
                // Replace on an empty stack degenerates to a push.
                if (is_empty) begin
                    sp_nxt = SP_ONE;
                end else begin
                    waddr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sp <= '0;
        end else begin
            sp <= sp_nxt;
        end
    end

`ifdef FIB_STACK_ERR_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            err <= 1'b0;
        end else if (ovf || unf) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = ovf ^ unf;
`endif

    // clr wins over a same-edge push, so the write is suppressed too.
    fib_stack_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we && !clr),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_idx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fib_stack.sv
// Self-checking bench for fib_stack: a queue-based reference stack predicts every
// cycle's top/count/flags; predictions go through exp_q and are checked after each edge.
module tb_fib_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = WIDTH + CW + 3;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] top;
    logic             is_empty, is_full;
    logic [CW-1:0]    count;
    logic             err_obs;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]     exp_q[$];
    logic [WIDTH-1:0] model[$];
    logic             model_err = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    fib_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .din      (din),
        .top      (top),
        .is_empty (is_empty),
        .is_full  (is_full),
`ifdef FIB_STACK_ERR_EN
        .err      (err_obs),
`endif
        .count    (count)
    );

`ifndef FIB_STACK_ERR_EN
    assign err_obs = 1'b0;
`endif

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (model.size() == 0) ? '0 : model[model.size() - 1];
    endfunction

    function automatic logic [W-1:0] model_pack();
        logic [CW-1:0] c;
        c = CW'(model.size());
        return {model_err, (model.size() == DEPTH), (model.size() == 0), c, model_top()};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        logic [W-1:0] e;
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        clr  = c;
        // The word visible while pop is asserted is the one about to be removed.
        if (q && !c) check("top_pre_pop", 32'(top), 32'(model_top()));
        if (c) begin
            model.delete();
            model_err = 1'b0;
        end else begin
            case ({p, q})
                2'b10: if (model.size() < DEPTH) model.push_back(d); else model_err = 1'b1;
                2'b01: if (model.size() > 0) void'(model.pop_back()); else model_err = 1'b1;
                2'b11: if (model.size() > 0) model[model.size() - 1] = d; else model.push_back(d);
                default: ;
            endcase
        end
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("top",      32'(top),      32'(e[WIDTH-1:0]));
        check("count",    32'(count),    32'(e[WIDTH +: CW]));
        check("is_empty", 32'(is_empty), 32'(e[WIDTH + CW]));
        check("is_full",  32'(is_full),  32'(e[WIDTH + CW + 1]));
`ifdef FIB_STACK_ERR_EN
        check("err",      32'(err_obs),  32'(e[WIDTH + CW + 2]));
`endif
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d); step(1'b1, 1'b0, d, 1'b0); endtask
    task automatic do_pop();                           step(1'b0, 1'b1, '0, 1'b0); endtask
    task automatic do_idle();                          step(1'b0, 1'b0, '0, 1'b0); endtask
    task automatic do_repl(input logic [WIDTH-1:0] d); step(1'b1, 1'b1, d, 1'b0); endtask
    task automatic do_clr();                           step(1'b0, 1'b0, '0, 1'b1); endtask

    // ---------------- stimulus ----------------
    initial begin
        do_clr();
        check("reset_top",   32'(top),      32'h0);
        check("reset_count", 32'(count),    32'h0);
        check("reset_empty", 32'(is_empty), 32'h1);

        // Basic push/pop ordering.
        do_push(8'h01); do_push(8'h01); do_push(8'h02);
        check("seq_count3", 32'(count), 32'd3);
        check("seq_top2",   32'(top),   32'h02);
        repeat (3) do_pop();
        check("seq_empty", 32'(is_empty), 32'h1);

        // Fill to DEPTH, then overflow.
        for (int i = 1; i <= DEPTH; i++) do_push(WIDTH'(i));
        check("full_flag", 32'(is_full), 32'h1);
        check("full_top",  32'(top),     32'(DEPTH));
        do_push(8'h55);
        check("ovf_top",   32'(top),     32'(DEPTH));
        check("ovf_count", 32'(count),   32'(DEPTH));
        do_repl(8'hA5);
        do_clr();

        // Underflow, sticky through idle cycles, cleared by clr.
        do_pop();
        check("unf_count", 32'(count), 32'h0);
        repeat (10) do_idle();
        do_clr();

        // Replace on non-empty and on empty.
        do_push(8'h0A);
        do_repl(8'h0B);
        check("repl_top", 32'(top), 32'h0B);
        do_clr();
        do_repl(8'h0C);
        check("repl_empty_top", 32'(top), 32'h0C);
        do_clr();

        // clr beats a same-cycle push.
        repeat (5) do_push(WIDTH'($urandom_range(0, 255)));
        step(1'b1, 1'b0, 8'h77, 1'b1);
        check("clr_prio_count", 32'(count), 32'h0);

        // Back-to-back traffic.
        repeat (8) do_push(WIDTH'($urandom_range(1, 255)));
        repeat (8) do_pop();

        // Random mix, biased so the stack visits both ends.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       do_clr();
            else if (r < 45) do_push(WIDTH'($urandom_range(0, 255)));
            else if (r < 80) do_pop();
            else if (r < 92) do_repl(WIDTH'($urandom_range(0, 255)));
            else             do_idle();
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
